// File: rtl/ras_driver.sv
// Command-side initiator for a return address stack: turns fetch call/return/branch
// events and branch resolutions into registered push/pop/branch/close commands.
module ras_driver #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 16,
    parameter int INSTR_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       f_valid,
    output logic                       f_ready,
    input  logic                       f_call,
    input  logic                       f_ret,
    input  logic                       f_branch,
    input  logic [WIDTH-1:0]           f_pc,
    input  logic                       res_valid,
    input  logic                       res_mispredict,
    output logic                       ras_push,
    output logic                       ras_pop,
    output logic                       ras_branch,
    output logic                       ras_close_valid,
    output logic                       ras_close_invalid,
    output logic [WIDTH-1:0]           ras_din,
    input  logic [WIDTH-1:0]           ras_dout,
    output logic                       pred_valid,
    output logic [WIDTH-1:0]           pred_target,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       err_underflow,
    output logic                       err_overflow,
    output logic                       err_spurious
);

    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW:0]      FULL = (OW + 1)'(DEPTH);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);

    typedef enum logic {IDLE, SPEC} state_t;

    state_t        state;
    state_t        state_next;
    logic [OW-1:0] snap;
    logic          pend;
    logic          pend_zero;
    logic          pred_zero;

    logic          accept;
    logic          resolve;
    logic          flush;
    logic          do_push;
    logic          do_pop;
    logic [OW:0]   eff;
    logic [OW:0]   eff_next;

    // occupancy lags the command outputs by a cycle, so decisions use the count
    // including the commands currently on the bus
    always_comb begin
        f_ready    = 1'b1;
        accept     = 1'b0;
        resolve    = 1'b0;
        flush      = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        eff        = {1'b0, occupancy} + {{OW{1'b0}}, ras_push} - {{OW{1'b0}}, ras_pop};
        eff_next   = eff;
        state_next = state;

        if (res_valid && res_mispredict)
            f_ready = 1'b0;
        if (f_branch && (state == SPEC || res_valid))
            f_ready = 1'b0;

        accept   = f_valid && f_ready;
        resolve  = res_valid && (state == SPEC);
        flush    = resolve && res_mispredict;
        do_push  = accept && f_call && (eff < FULL);
        do_pop   = accept && f_ret && (eff != '0);
        eff_next = eff + {{OW{1'b0}}, do_push} - {{OW{1'b0}}, do_pop};

        case (state)
            IDLE:    if (accept && f_branch) state_next = SPEC;
            SPEC:    if (res_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // commands, occupancy bookkeeping and the snapshot used to undo a mispredicted window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ras_push          <= 1'b0;
            ras_pop           <= 1'b0;
            ras_branch        <= 1'b0;
            ras_close_valid   <= 1'b0;
            ras_close_invalid <= 1'b0;
            ras_din           <= '0;
            occupancy         <= '0;
            snap              <= '0;
            err_underflow     <= 1'b0;
            err_overflow      <= 1'b0;
            err_spurious      <= 1'b0;
        end else begin
            ras_push          <= do_push;
            ras_pop           <= do_pop;
            ras_branch        <= accept && f_branch;
            ras_close_valid   <= resolve && !res_mispredict;
            ras_close_invalid <= flush;
            if (do_push)
                ras_din <= f_pc + STEP;
            occupancy <= flush ? snap : eff[OW-1:0];
            if (accept && f_branch)
                snap <= eff_next[OW-1:0];
            if (accept && f_ret && eff == '0)
                err_underflow <= 1'b1;
            if (accept && f_call && eff >= FULL)
                err_overflow <= 1'b1;
            if (res_valid && state == IDLE)
                err_spurious <= 1'b1;
        end
    end

    // two-stage prediction pipe; a flush kills whatever is in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend       <= 1'b0;
            pend_zero  <= 1'b0;
            pred_valid <= 1'b0;
            pred_zero  <= 1'b0;
        end else begin
            pend       <= accept && f_ret && !flush;
            pend_zero  <= !do_pop;
            pred_valid <= pend && !flush;
            pred_zero  <= pend_zero;
        end
    end

    assign pred_target = (pred_valid && !pred_zero) ? ras_dout : '0;

endmodule

// File: tb/tb_ras_driver.sv
// Directed, table-driven bench for ras_driver with a fixed stack top value
// and a per-cycle protocol invariant monitor.
module tb_ras_driver;

    localparam logic [31:0] DOUT = 32'hdead_bee0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        f_valid = 1'b0;
    logic        f_ready;
    logic        f_call = 1'b0;
    logic        f_ret = 1'b0;
    logic        f_branch = 1'b0;
    logic [31:0] f_pc = '0;
    logic        res_valid = 1'b0;
    logic        res_mispredict = 1'b0;
    logic        ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid;
    logic [31:0] ras_din;
    logic [31:0] ras_dout = DOUT;
    logic        pred_valid;
    logic [31:0] pred_target;
    logic [4:0]  occupancy;
    logic        err_underflow, err_overflow, err_spurious;

    int total = 0;
    int bad = 0;

    ras_driver #(.WIDTH(32), .DEPTH(16), .INSTR_BYTES(4)) dut (
        .clk(clk), .reset(reset),
        .f_valid(f_valid), .f_ready(f_ready), .f_call(f_call), .f_ret(f_ret),
        .f_branch(f_branch), .f_pc(f_pc),
        .res_valid(res_valid), .res_mispredict(res_mispredict),
        .ras_push(ras_push), .ras_pop(ras_pop), .ras_branch(ras_branch),
        .ras_close_valid(ras_close_valid), .ras_close_invalid(ras_close_invalid),
        .ras_din(ras_din), .ras_dout(ras_dout),
        .pred_valid(pred_valid), .pred_target(pred_target), .occupancy(occupancy),
        .err_underflow(err_underflow), .err_overflow(err_overflow), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv, c, r, b;
        logic [31:0] pc;
        logic        rv, rm;
        logic        rdy;
        logic [8:0]  cmd;   // {push, pop, branch, close_valid, close_invalid, pred_valid, spurious, overflow, underflow}
        logic [4:0]  occ;
        logic [31:0] din;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] ev, input logic [31:0] pc, input logic [1:0] res,
                                input logic rdy, input logic [8:0] cmd, input logic [4:0] occ,
                                input logic [31:0] din, input logic [31:0] tgt);
        vec_t v;
        {v.fv, v.c, v.r, v.b} = ev;
        v.pc  = pc;
        {v.rv, v.rm} = res;
        v.rdy = rdy;
        v.cmd = cmd;
        v.occ = occ;
        v.din = din;
        v.tgt = tgt;
        return v;
    endfunction

    function automatic logic [8:0] cmd_now();
        return {ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid,
                pred_valid, err_spurious, err_overflow, err_underflow};
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        f_valid        = v.fv;
        f_call         = v.c;
        f_ret          = v.r;
        f_branch       = v.b;
        f_pc           = v.pc;
        res_valid      = v.rv;
        res_mispredict = v.rm;
    endtask

    task automatic idle_inputs();
        f_valid = 0; f_call = 0; f_ret = 0; f_branch = 0; f_pc = '0;
        res_valid = 0; res_mispredict = 0;
    endtask

    // protocol invariants, sampled away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            total++;
            if ((ras_branch && (ras_close_valid || ras_close_invalid)) ||
                (ras_close_valid && ras_close_invalid) ||
                (ras_pop && occupancy == 5'd0)) begin
                bad++;
                $display("[TB] FAIL invariant: branch=%0b cv=%0b ci=%0b pop=%0b occ=%0d",
                         ras_branch, ras_close_valid, ras_close_invalid, ras_pop, occupancy);
            end
        end
    end

    initial begin
        int pushes;

        // calls, ret, underflow ret
        vecs.push_back(mk(4'b1100, 32'h100, 2'b00, 1, 9'b100000_000, 0, 32'h104, 0));
        vecs.push_back(mk(4'b1100, 32'h200, 2'b00, 1, 9'b100000_000, 1, 32'h204, 0));
        vecs.push_back(mk(4'b1010, 32'h0,   2'b00, 1, 9'b010000_000, 2, 0, 0));
        vecs.push_back(mk(4'b0000, 32'h0,   2'b00, 1, 9'b000001_000, 1, 0, DOUT));
        vecs.push_back(mk(4'b0000, 32'h0,   2'b00, 1, 9'b000000_000, 1, 0, 0));
        vecs.push_back(mk(4'b1010, 32'h0,   2'b00, 1, 9'b010000_000, 1, 0, 0));
        vecs.push_back(mk(4'b1010, 32'h0,   2'b00, 1, 9'b000001_001, 0, 0, DOUT));
        vecs.push_back(mk(4'b0000, 32'h0,   2'b00, 1, 9'b000001_001, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 32'h0,   2'b00, 1, 9'b000000_001, 0, 0, 0));
        // branch at occupancy 3, two rets, mispredict restores 3
        vecs.push_back(mk(4'b1100, 32'h300, 2'b00, 1, 9'b100000_001, 0, 32'h304, 0));
        vecs.push_back(mk(4'b1100, 32'h400, 2'b00, 1, 9'b100000_001, 1, 32'h404, 0));
        vecs.push_back(mk(4'b1100, 32'h500, 2'b00, 1, 9'b100000_001, 2, 32'h504, 0));
        vecs.push_back(mk(4'b1001, 32'h0,   2'b00, 1, 9'b001000_001, 3, 0, 0));
        vecs.push_back(mk(4'b1010, 32'h0,   2'b00, 1, 9'b010000_001, 3, 0, 0));
        vecs.push_back(mk(4'b1010, 32'h0,   2'b00, 1, 9'b010001_001, 2, 0, DOUT));
        vecs.push_back(mk(4'b1100, 32'h999, 2'b11, 0, 9'b000010_001, 3, 0, 0));
        vecs.push_back(mk(4'b0000, 32'h0,   2'b00, 1, 9'b000000_001, 3, 0, 0));
        // close_valid together with a call
        vecs.push_back(mk(4'b1001, 32'h0,   2'b00, 1, 9'b001000_001, 3, 0, 0));
        vecs.push_back(mk(4'b1100, 32'h600, 2'b00, 1, 9'b100000_001, 3, 32'h604, 0));
        vecs.push_back(mk(4'b1100, 32'h700, 2'b10, 1, 9'b100100_001, 4, 32'h704, 0));
        vecs.push_back(mk(4'b0000, 32'h0,   2'b00, 1, 9'b000000_001, 5, 0, 0));
        // branch held while in SPEC, then spurious resolve in IDLE
        vecs.push_back(mk(4'b1001, 32'h0,   2'b00, 1, 9'b001000_001, 5, 0, 0));
        vecs.push_back(mk(4'b1001, 32'h0,   2'b00, 0, 9'b000000_001, 5, 0, 0));
        vecs.push_back(mk(4'b1001, 32'h0,   2'b10, 0, 9'b000100_001, 5, 0, 0));
        vecs.push_back(mk(4'b1001, 32'h0,   2'b00, 1, 9'b001000_001, 5, 0, 0));
        vecs.push_back(mk(4'b0000, 32'h0,   2'b10, 1, 9'b000100_001, 5, 0, 0));
        vecs.push_back(mk(4'b0000, 32'h0,   2'b10, 1, 9'b000000_101, 5, 0, 0));
        vecs.push_back(mk(4'b0000, 32'h0,   2'b00, 1, 9'b000000_101, 5, 0, 0));

        #1;
        check_output("reset cmds", cmd_now(), 0);
        check_output("reset occupancy", occupancy, 0);
        check_output("reset din", ras_din, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            #1;
            check_output($sformatf("v%0d f_ready", i), f_ready, vecs[i].rdy);
            @(posedge clk);
            #1;
            check_output($sformatf("v%0d cmds", i), cmd_now(), vecs[i].cmd);
            check_output($sformatf("v%0d occupancy", i), occupancy, vecs[i].occ);
            check_output($sformatf("v%0d pred_target", i), pred_target, vecs[i].tgt);
            if (vecs[i].cmd[8])
                check_output($sformatf("v%0d ras_din", i), ras_din, vecs[i].din);
        end
        idle_inputs();

        // open a window, then reset asynchronously in the middle of it
        f_valid = 1; f_branch = 1;
        #1 check_output("mid branch ready", f_ready, 1);
        @(posedge clk);
        #1 check_output("mid branch issued", ras_branch, 1);
        idle_inputs();
        reset = 1'b0;
        #1;
        check_output("async reset cmds", cmd_now(), 0);
        check_output("async reset occupancy", occupancy, 0);
        check_output("async reset din", ras_din, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        res_valid = 1;
        #1 check_output("post reset ready", f_ready, 1);
        @(posedge clk);
        #1;
        check_output("post reset no close", {ras_close_valid, ras_close_invalid}, 0);
        check_output("post reset spurious", err_spurious, 1);
        idle_inputs();

        // DEPTH+1 calls saturate at DEPTH
        pushes = 0;
        for (int i = 0; i < 17; i++) begin
            f_valid = 1; f_call = 1; f_pc = 32'h1000 + 32'(i) * 32'h10;
            @(posedge clk);
            #1;
            if (ras_push) pushes++;
            if (i == 15) check_output("overflow last din", ras_din, 32'h10f4);
        end
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_output("overflow push count", pushes, 16);
        check_output("overflow occupancy", occupancy, 16);
        check_output("overflow flag", err_overflow, 1);
        check_output("overflow underflow clear", err_underflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
